// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks of the mimas_a7 UART test.
//   rx_state_t      : receiver state encoding
//   DATA_BITS       : payload width of one 8N1 frame
//   clocks_per_bit  : integer clk cycles per line bit (also used by uart_tx)
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam int DATA_BITS = 8;

    // Whole clk cycles per bit; the fractional remainder is dropped.
    function automatic int clocks_per_bit(input int clk_frequency, input int baud_rate);
        return clk_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Byte output side of the UART receiver.
//   data          : received byte, stable while data_valid=1
//   data_valid    : data holds an unconsumed byte
//   data_ready    : consumer takes data on a clk edge where data_valid=1
//   framing_error : one-cycle pulse, stop bit sampled low
//   overrun       : one-cycle pulse, good byte dropped because buffer full
// master = receiver, slave = consumer.
// -----------------------------------------------------------------------------
interface uart_rx_if;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       framing_error;
    logic       overrun;

    modport master (
        output data,
        output data_valid,
        output framing_error,
        output overrun,
        input  data_ready
    );

    modport slave (
        input  data,
        input  data_valid,
        input  framing_error,
        input  overrun,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_bit_synchronizer.sv
// -----------------------------------------------------------------------------
// bit_synchronizer
// Two-flop synchronizer for a single asynchronous bit.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset, both flops load RESET_VALUE
//   d       : asynchronous input
//   q       : synchronized output
// -----------------------------------------------------------------------------
module bit_synchronizer #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Metastability filter chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= RESET_VALUE;
            sync_r <= RESET_VALUE;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. Samples the synchronized rx line in the middle of each
// bit, presents each good byte on a one-entry valid/ready buffer and pulses
// framing_error / overrun for bad or dropped frames.
//   clk     : single clock
//   reset_n : asynchronous active-low reset (deassertion already clk-aligned)
//   rx      : asynchronous serial line, idles high
//   bus     : uart_rx_if master (data, data_valid, data_ready,
//             framing_error, overrun)
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 100000000,
    parameter int BAUD_RATE     = 115200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    uart_rx_if.master  bus
);

    localparam int CLOCKS_PER_BIT = clocks_per_bit(CLK_FREQUENCY, BAUD_RATE);
    localparam int HALF_BIT       = CLOCKS_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CLOCKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Fewer than 4 clocks per bit leaves no room for mid-bit sampling.
    generate
        if (CLOCKS_PER_BIT < 4) begin : g_rate_check
            $error("uart_rx: CLOCKS_PER_BIT must be at least 4");
        end
    endgenerate

    logic             rx_s;
    rx_state_t        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       idx_r;
    logic [7:0]       shift_r;
    logic [7:0]       data_r;
    logic             data_valid_r;
    logic             framing_error_r;
    logic             overrun_r;

    logic             sample_s;
    logic             stop_sample_s;
    logic             load_s;
    logic             drop_s;
    logic             bad_stop_s;

    // rx synchronizer idles high so reset never looks like a start bit.
    bit_synchronizer #(
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    assign sample_s      = (cnt_r == CNT_ZERO);
    assign stop_sample_s = (state_r == STOP) && sample_s;

    // Stop-bit outcome: load into the buffer, drop as overrun, or framing error.
    // A pop on the same edge frees the buffer for the incoming byte.
    always_comb begin
        load_s     = 1'b0;
        drop_s     = 1'b0;
        bad_stop_s = 1'b0;
        if (stop_sample_s) begin
            if (rx_s) begin
                if (!data_valid_r || bus.data_ready) begin
                    load_s = 1'b1;
                end else begin
                    drop_s = 1'b1;
                end
            end else begin
                bad_stop_s = 1'b1;
            end
        end else begin
            load_s     = 1'b0;
            drop_s     = 1'b0;
            bad_stop_s = 1'b0;
        end
    end

    // Frame sequencer: start detect, mid-bit sampling and bit shifting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!rx_s) begin
                        state_r <= START;
                        cnt_r   <= CNT_HALF;
                    end
                end
                START: begin
                    if (sample_s) begin
                        if (!rx_s) begin
                            state_r <= DATA;
                            cnt_r   <= CNT_FULL;
                            idx_r   <= 3'd0;
                        end else begin
                            // Start bit vanished before mid-bit: line glitch.
                            state_r <= IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                DATA: begin
                    if (sample_s) begin
                        shift_r <= {rx_s, shift_r[7:1]};
                        cnt_r   <= CNT_FULL;
                        idx_r   <= idx_r + 3'd1;
                        if (idx_r == 3'd7) begin
                            state_r <= STOP;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                STOP: begin
                    if (sample_s) begin
                        state_r <= rx_s ? IDLE : BREAK;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                BREAK: begin
                    // Wait for the line to return high before hunting again.
                    if (rx_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                    idx_r   <= 3'd0;
                end
            endcase
        end
    end

    // One-entry output buffer and error pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r          <= 8'h00;
            data_valid_r    <= 1'b0;
            framing_error_r <= 1'b0;
            overrun_r       <= 1'b0;
        end else begin
            framing_error_r <= bad_stop_s;
            overrun_r       <= drop_s;
            if (load_s) begin
                data_r       <= shift_r;
                data_valid_r <= 1'b1;
            end else if (data_valid_r && bus.data_ready) begin
                data_valid_r <= 1'b0;
            end
        end
    end

    assign bus.data          = data_r;
    assign bus.data_valid    = data_valid_r;
    assign bus.framing_error = framing_error_r;
    assign bus.overrun       = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Scoreboard bench for uart_rx at CLK_FREQUENCY=1600, BAUD_RATE=100
// (16 clocks per bit). Frames are serialized by the bench; each frame's
// expected outcome (byte delivered, framing error, overrun) is queued when it
// is sent and a free-running monitor compares what the DUT presents.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 16;

    logic clk;
    logic reset_n;
    logic rx;

    uart_rx_if bus();

    uart_rx #(
        .CLK_FREQUENCY (1600),
        .BAUD_RATE     (100)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (rx),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];
    int         pending_fe  = 0;
    int         pending_ovr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: got 0x%0h, expected nothing", name, act);
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serialize one frame. stop_low=0 sends a proper stop bit; otherwise the
    // line is held low for stop_low cycles instead and then released.
    task automatic send_frame(input logic [7:0] b, input int stop_low);
        rx = 1'b0;
        wait_edges(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_edges(CPB);
        end
        if (stop_low == 0) begin
            rx = 1'b1;
            wait_edges(CPB);
        end else begin
            rx = 1'b0;
            wait_edges(stop_low);
            rx = 1'b1;
            wait_edges(2);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_data"},  {24'h0, bus.data}, 32'h0);
        check({name, "_valid"}, {31'h0, bus.data_valid}, 32'h0);
        check({name, "_fe"},    {31'h0, bus.framing_error}, 32'h0);
        check({name, "_ovr"},   {31'h0, bus.overrun}, 32'h0);
    endtask

    // Monitor: compares consumed bytes and error pulses against the scoreboard.
    initial begin : monitor
        logic prev_fe;
        logic prev_ovr;
        logic [7:0] e;
        prev_fe  = 1'b0;
        prev_ovr = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_fe  = 1'b0;
                prev_ovr = 1'b0;
            end else begin
                if (bus.data_valid && bus.data_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_byte", {24'h0, bus.data});
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", {24'h0, bus.data}, {24'h0, e});
                    end
                end
                if (bus.framing_error) begin
                    check("fe_pulse_width", {31'h0, prev_fe}, 32'h0);
                    if (pending_fe > 0) begin
                        pending_fe--;
                        tests_run++;
                    end else begin
                        fail_now("unexpected_framing_error", 32'h1);
                    end
                end
                if (bus.overrun) begin
                    check("ovr_pulse_width", {31'h0, prev_ovr}, 32'h0);
                    if (pending_ovr > 0) begin
                        pending_ovr--;
                        tests_run++;
                    end else begin
                        fail_now("unexpected_overrun", 32'h1);
                    end
                end
                prev_fe  = bus.framing_error;
                prev_ovr = bus.overrun;
            end
        end
    end

    // Hard time limit.
    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] b;
        int         gap;
        int         budget;

        // ---- reset with a toggling line ----
        reset_n        = 1'b0;
        rx             = 1'b1;
        bus.data_ready = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) begin
            rx = 1'($urandom_range(0, 1));
            wait_edges(1);
            check_idle_outputs("reset");
        end
        rx = 1'b1;
        wait_edges(4);
        reset_n = 1'b1;
        wait_edges(4);
        check_idle_outputs("post_reset");

        // ---- 0xA5 with latency E0+154, pop on the next edge ----
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 0);
            begin
                wait_edges(154);
                check("a5_valid_before", {31'h0, bus.data_valid}, 32'h0);
                wait_edges(1);
                check("a5_valid_at", {31'h0, bus.data_valid}, 32'h1);
                check("a5_data_at", {24'h0, bus.data}, 32'hA5);
                wait_edges(1);
                check("a5_valid_after", {31'h0, bus.data_valid}, 32'h0);
            end
        join

        // ---- glitch start then 0x5A ----
        rx = 1'b0;
        wait_edges(4);
        rx = 1'b1;
        wait_edges(30);
        check("glitch_valid", {31'h0, bus.data_valid}, 32'h0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 0);

        // ---- framing error / break then 0x55 ----
        pending_fe++;
        send_frame(8'h3C, 40);
        check("fe_valid", {31'h0, bus.data_valid}, 32'h0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 0);
        wait_edges(4);

        // ---- overrun: 0x11 held, 0x22 dropped ----
        bus.data_ready = 1'b0;
        exp_q.push_back(8'h11);
        pending_ovr++;
        fork
            begin
                send_frame(8'h11, 0);
                send_frame(8'h22, 0);
            end
            begin
                wait_edges(315);
                check("ovr_pulse", {31'h0, bus.overrun}, 32'h1);
                check("ovr_data_kept", {24'h0, bus.data}, 32'h11);
                check("ovr_valid", {31'h0, bus.data_valid}, 32'h1);
            end
        join
        wait_edges(3);
        bus.data_ready = 1'b1;
        wait_edges(2);
        check("ovr_drained", {31'h0, bus.data_valid}, 32'h0);

        // ---- pop and load on the same edge ----
        bus.data_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 0);
        wait_edges(5);
        exp_q.push_back(8'h22);
        fork
            send_frame(8'h22, 0);
            begin
                wait_edges(154);
                bus.data_ready = 1'b1;
                wait_edges(1);
                bus.data_ready = 1'b0;
                check("swap_valid", {31'h0, bus.data_valid}, 32'h1);
                check("swap_data", {24'h0, bus.data}, 32'h22);
                check("swap_ovr", {31'h0, bus.overrun}, 32'h0);
            end
        join

        // ---- reset in the middle of 0xF0 (0x22 still pending) ----
        fork
            send_frame(8'hF0, 0);
            begin
                wait_edges(56);
                #3;
                reset_n = 1'b0;
                #1;
                exp_q.delete();
                pending_fe  = 0;
                pending_ovr = 0;
                check_idle_outputs("midframe_reset");
            end
        join
        wait_edges(2);
        reset_n = 1'b1;
        wait_edges(3);
        bus.data_ready = 1'b1;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 0);

        // ---- randomized frames, gaps and framing errors ----
        for (int n = 0; n < 24; n++) begin
            b   = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 4);
            if ($urandom_range(0, 5) == 0) begin
                pending_fe++;
                send_frame(b, $urandom_range(16, 48));
            end else begin
                exp_q.push_back(b);
                send_frame(b, 0);
            end
            if (gap > 0) begin
                wait_edges(gap);
            end
        end

        // ---- drain ----
        budget = 500;
        while ((exp_q.size() != 0 || pending_fe != 0 || pending_ovr != 0) && budget > 0) begin
            wait_edges(1);
            budget--;
        end
        check("left_bytes", exp_q.size(), 32'h0);
        check("left_fe", pending_fe, 32'h0);
        check("left_ovr", pending_ovr, 32'h0);
        check("final_valid", {31'h0, bus.data_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver for the mimas_a7 UART test.
- Sits directly downstream of the reset synchronizer. Its reset_n input is the synchronized reset, so assertion is asynchronous and deassertion is aligned to clk.
- Converts the asynchronous serial rx pin into bytes.
- Presents each byte on a one-entry valid/ready output buffer and reports framing and overrun errors.

Parameters:
- CLK_FREQUENCY, 100000000, clk frequency in Hz.
- BAUD_RATE, 115200, line rate in baud.
- Derived localparam CLOCKS_PER_BIT = CLK_FREQUENCY / BAUD_RATE (integer division). Elaboration fails if it is below 4.
- Derived localparam HALF_BIT = CLOCKS_PER_BIT / 2.

Ports:
- reset_n  in  1  asynchronous active-low reset. Assertion is asynchronous; deassertion arrives synchronous to clk from the reset synchronizer.
- clk  in  1  single clock for all logic.
- rx  in  1  asynchronous serial line; idles high.
- data  out  8  received byte; stable while data_valid=1.
- data_valid  out  1  data holds an unconsumed byte.
- data_ready  in  1  consumer accepts data on a rising edge where data_valid=1.
- framing_error  out  1  one-cycle pulse when the stop bit is sampled low.
- overrun  out  1  one-cycle pulse when a good byte is dropped because the buffer is full.

Behaviour:
- Reset values (applied asynchronously while reset_n=0):
  - data=0, data_valid=0, framing_error=0, overrun=0.
  - State = IDLE; bit counter and bit index = 0.
  - Both rx synchronizer flops = 1.
- rx passes through a 2-flop synchronizer giving rx_s. All decisions use rx_s only.
- IDLE: when rx_s=0, go to START and load counter = HALF_BIT-1.
- Counter rule: in START, DATA and STOP the counter decrements every cycle. The "sample edge" is the edge where the counter is 0.
- START, at sample edge:
  - rx_s=0: go to DATA, counter = CLOCKS_PER_BIT-1, index = 0.
  - rx_s=1: glitch; return to IDLE with no error.
- DATA, at each sample edge:
  - Shift rx_s into shift[7] with right shift, so bits are LSB first.
  - Reload counter = CLOCKS_PER_BIT-1.
  - Increment index; after the 8th bit (index 7) go to STOP.
- STOP, at sample edge:
  - rx_s=1 and buffer free (data_valid=0, or data_valid & data_ready this edge): data <= shift, data_valid <= 1, go to IDLE.
  - rx_s=1 and buffer full with no pop: overrun pulses 1 cycle; old data is kept; go to IDLE.
  - rx_s=0: framing_error pulses 1 cycle; byte is dropped; go to BREAK.
- BREAK: stay until rx_s=1, then go to IDLE. This prevents a held-low line from re-triggering starts.
- Output buffer:
  - data_valid clears on an edge with data_valid & data_ready unless the same edge loads a new byte, in which case it stays 1 with new data.
  - data_ready while data_valid=0 is ignored.
- Latency: let E0 be the first clk edge after rx falls. data_valid is high after edge E0+2+HALF_BIT+9*CLOCKS_PER_BIT.
- Next start: a new start bit is detectable from the cycle after the STOP sample. Back-to-back frames with no idle gap are received.
- Reset mid-frame: everything returns to reset values at once; any partial byte is discarded.

Decomposition:
- Shared package uart_pkg:
  - typedef enum rx_state_t {IDLE, START, DATA, STOP, BREAK};
  - function clocks_per_bit(clk_frequency, baud_rate), also used by the future uart_tx.
- Sub-module bit_synchronizer: 2-flop, parameterized reset value (1 here), clk/reset_n ports; used for rx.

Test Plan (CLK_FREQUENCY=1600, BAUD_RATE=100 → CLOCKS_PER_BIT=16, HALF_BIT=8):
- Reset/basic: hold reset_n=0 while toggling rx → all outputs 0. Release, send 0xA5, data_ready=1 → data=0xA5 and data_valid=1 after edge E0+154, valid cleared the next edge.
- Glitch: rx low for 4 cycles then high → no data_valid, no framing_error, state back in IDLE. A following 0x5A is received correctly.
- Framing/break: send 0x3C with rx held low for 40 cycles after the data bits → framing_error pulses exactly 1 cycle, data_valid=0, no start detected until rx=1. Then 0x55 is received correctly.
- Overrun: data_ready=0, send 0x11 then 0x22 → data=0x11 held, overrun pulses at the second STOP sample. Then data_ready=1 → 0x11 consumed, data_valid=0.
- Simultaneous pop/load: 0x11 pending; data_ready=1 exactly on the STOP sample edge of 0x22 → data=0x22, data_valid stays 1, overrun=0.
- Reset mid-frame: assert reset_n during bit 3 of 0xF0 → outputs clear immediately. After release, 0x81 is received correctly with no stale bits.
